// File: rtl/gpu_pkg.sv
// Shared definitions for the scheduler-to-core program-frame stream.
//   rx_state_t      : core-side receiver state (IDLE, LOAD, START, RUN)
//   HDR_LEN_MSB/LSB : location of the frame count N inside a header beat
//   BEATS_PER_FRAME : bus beats per frame at the default bus/instruction sizes
//   beats_per_frame : the same figure for any parameterisation
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } rx_state_t;

  // Header layout, shared with the scheduler that builds the headers.
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 15;

  function automatic int beats_per_frame(input int frame_size,
                                         input int instr_size,
                                         input int bus_width);
    return (frame_size * instr_size) / bus_width;
  endfunction

  localparam int BEATS_PER_FRAME = beats_per_frame(16, 16, 32);

endpackage

// File: rtl/core_frame_receiver.sv
// Core-side receiver for the program-frame stream.
// Accepts a header beat (frame count N), then N*BEATS_PER_FRAME payload beats
// addressed to this core, and writes each beat into the local instruction
// memory one cycle after it is accepted. When the last beat lands, it pulses
// prog_start and then holds off the bus until the core reports core_done.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   bus_valid/sop/data/dest, bus_ready : scheduler bus, beat accepted when
//                     valid & ready & dest[CORE_ID]
//   core_ready, core_reading : status decoded from state
//   imem_we/addr/wdata : registered instruction-memory write port
//   prog_start, prog_len : one-cycle load-complete pulse and frame count
//   core_done       : core finished executing the current program
//   load_error      : sticky protocol-error flag
module core_frame_receiver
  import gpu_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int CORE_NUM    = 16,
  parameter int INSTR_SIZE  = 16,
  parameter int FRAME_SIZE  = 16,
  parameter int BUS_TO_CORE = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int IMEM_AW     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bus_valid,
  input  logic                   bus_sop,
  input  logic [BUS_TO_CORE-1:0] bus_data,
  input  logic [CORE_NUM-1:0]    bus_dest,
  output logic                   bus_ready,
  output logic                   core_ready,
  output logic                   core_reading,
  output logic                   imem_we,
  output logic [IMEM_AW-1:0]     imem_addr,
  output logic [BUS_TO_CORE-1:0] imem_wdata,
  output logic                   prog_start,
  output logic [15:0]            prog_len,
  input  logic                   core_done,
  output logic                   load_error
);

  localparam int BPF = beats_per_frame(FRAME_SIZE, INSTR_SIZE, BUS_TO_CORE);

  rx_state_t              state_reg, state_next;
  logic [15:0]            n_reg, n_next;
  logic [IMEM_AW-1:0]     beat_cnt_reg, beat_cnt_next;
  logic                   err_reg, err_next;
  logic                   we_reg, we_next;
  logic [IMEM_AW-1:0]     addr_reg, addr_next;
  logic [BUS_TO_CORE-1:0] wdata_reg, wdata_next;
  logic                   start_reg, start_next;
  logic [15:0]            len_reg, len_next;

  logic        accept;
  logic [15:0] hdr_len;
  logic [31:0] hdr_total;
  logic        hdr_ok;
  logic [31:0] n_total;
  logic        last_beat;
  logic        unused_dest;

  // Only our own destination bit matters; the rest of the mask is for peers.
  assign unused_dest = ^bus_dest;

  assign bus_ready    = (state_reg == IDLE) || (state_reg == LOAD);
  assign core_ready   = (state_reg == IDLE);
  assign core_reading = (state_reg == LOAD);

  assign accept    = bus_valid && bus_ready && bus_dest[CORE_ID];
  assign hdr_len   = bus_data[HDR_LEN_MSB:HDR_LEN_LSB];
  // 32-bit arithmetic so a large N cannot alias into a small beat total.
  assign hdr_total = 32'(hdr_len) * 32'(BPF);
  assign hdr_ok    = (hdr_len != 16'd0) && (hdr_total <= 32'(IMEM_DEPTH));
  assign n_total   = 32'(n_reg) * 32'(BPF);
  assign last_beat = (32'(beat_cnt_reg) + 32'd1) == n_total;

  always_comb begin
    state_next    = state_reg;
    n_next        = n_reg;
    beat_cnt_next = beat_cnt_reg;
    err_next      = err_reg;
    we_next       = 1'b0;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    start_next    = 1'b0;
    len_next      = len_reg;
    case (state_reg)
      IDLE, LOAD: begin
        if (accept) begin
          if (bus_sop) begin
            // A header seen mid-load aborts that load (error stays set) and
            // is then treated exactly like a header arriving in IDLE.
            if (hdr_ok) begin
              state_next    = LOAD;
              n_next        = hdr_len;
              beat_cnt_next = '0;
              err_next      = (state_reg == LOAD);
            end else begin
              state_next = IDLE;
              err_next   = 1'b1;
            end
          end else if (state_reg == IDLE) begin
            err_next = 1'b1;
          end else begin
            we_next       = 1'b1;
            addr_next     = beat_cnt_reg;
            wdata_next    = bus_data;
            beat_cnt_next = beat_cnt_reg + 1'b1;
            if (last_beat) begin
              state_next = START;
              start_next = 1'b1;
              len_next   = n_reg;
            end
          end
        end
      end
      START:   state_next = RUN;
      RUN:     if (core_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      n_reg        <= '0;
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      start_reg    <= 1'b0;
      len_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      n_reg        <= n_next;
      beat_cnt_reg <= beat_cnt_next;
      err_reg      <= err_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      start_reg    <= start_next;
      len_reg      <= len_next;
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign prog_start = start_reg;
  assign prog_len   = len_reg;
  assign load_error = err_reg;

endmodule

// File: tb/tb_core_frame_receiver.sv
// Self-checking bench for core_frame_receiver (CORE_ID=2).
// A transaction-level model tracks phase, beats received and expected writes;
// a compare process checks every DUT output against it on each falling edge.
module tb_core_frame_receiver;

  localparam int BPF   = gpu_pkg::BEATS_PER_FRAME;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_valid = 1'b0, bus_sop = 1'b0, core_done = 1'b0;
  logic [31:0] bus_data = '0;
  logic [15:0] bus_dest = '0;
  logic        bus_ready, core_ready, core_reading, imem_we, prog_start, load_error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] prog_len;

  core_frame_receiver #(.CORE_ID(2)) dut (
    .clk(clk), .reset(reset),
    .bus_valid(bus_valid), .bus_sop(bus_sop), .bus_data(bus_data), .bus_dest(bus_dest),
    .bus_ready(bus_ready), .core_ready(core_ready), .core_reading(core_reading),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .prog_start(prog_start), .prog_len(prog_len),
    .core_done(core_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 loading, 2 start cycle, 3 running
  int          m_phase = 0, m_n = 0, m_got = 0;
  bit          m_err = 0, e_we = 0, e_start = 0;
  logic [7:0]  e_addr = '0;
  logic [31:0] e_wdata = '0;
  logic [15:0] e_len = '0;

  task automatic m_reset();
    m_phase = 0; m_n = 0; m_got = 0; m_err = 0;
    e_we = 0; e_start = 0; e_addr = '0; e_wdata = '0; e_len = '0;
  endtask

  task automatic m_header(input logic [15:0] n);
    if (n == 0 || int'(n) * BPF > DEPTH) begin
      m_phase = 0; m_err = 1;
    end else begin
      m_phase = 1; m_n = int'(n); m_got = 0; m_err = 0;
    end
  endtask

  task automatic m_step();
    bit acc;
    acc = bus_valid && (m_phase <= 1) && bus_dest[2];
    e_we = 0; e_start = 0;
    case (m_phase)
      0: if (acc) begin
        if (bus_sop) m_header(bus_data[15:0]);
        else m_err = 1;
      end
      1: if (acc) begin
        if (bus_sop) begin
          m_header(bus_data[15:0]);
          m_err = 1;
        end else begin
          e_we = 1; e_addr = m_got[7:0]; e_wdata = bus_data;
          m_got++;
          if (m_got == m_n * BPF) begin
            m_phase = 2; e_start = 1; e_len = 16'(m_n);
          end
        end
      end
      2: m_phase = 3;
      default: if (core_done) m_phase = 0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) m_reset();
    else m_step();
  end

  // ---------------- compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] mem_log [DEPTH];
  int start_cnt = 0;
  int wr_cnt = 0;

  initial forever begin
    @(negedge clk);
    chk("bus_ready",    32'(bus_ready),    32'(m_phase <= 1));
    chk("core_ready",   32'(core_ready),   32'(m_phase == 0));
    chk("core_reading", 32'(core_reading), 32'(m_phase == 1));
    chk("imem_we",      32'(imem_we),      32'(e_we));
    chk("prog_start",   32'(prog_start),   32'(e_start));
    chk("prog_len",     32'(prog_len),     32'(e_len));
    chk("load_error",   32'(load_error),   32'(m_err));
    if (e_we) begin
      chk("imem_addr",  32'(imem_addr), 32'(e_addr));
      chk("imem_wdata", imem_wdata,     e_wdata);
    end
    if (imem_we) begin
      mem_log[imem_addr] = imem_wdata;
      wr_cnt++;
    end
    if (prog_start) start_cnt++;
    $display("cyc t=%0t ph=%0d we=%0b addr=%0d data=%h start=%0b len=%0d err=%0b",
             $time, m_phase, imem_we, imem_addr, imem_wdata, prog_start, prog_len, load_error);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input bit s, input logic [31:0] d,
                       input logic [15:0] dst, input bit done);
    @(negedge clk); #1;
    bus_valid = v; bus_sop = s; bus_data = d; bus_dest = dst; core_done = done;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 16'h0, 0);
  endtask

  task automatic load_frames(input int n, input logic [31:0] base);
    drive(1, 1, 32'(n), 16'h0004, 0);
    for (int i = 0; i < n * BPF; i++) drive(1, 0, base + 32'(i), 16'h0004, 0);
  endtask

  int s0, w0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_log[i] = '0;
    // Reset with random traffic on the bus.
    for (int i = 0; i < 5; i++)
      drive(1, 1'($urandom), $urandom, 16'($urandom), 1'($urandom));
    chk("rst_core_ready", 32'(core_ready), 32'd1);
    chk("rst_bus_ready",  32'(bus_ready),  32'd1);
    @(negedge clk); #1; reset = 1'b1;
    idle(2);

    // Single-frame load.
    s0 = start_cnt;
    load_frames(1, 32'hA000_0000);
    idle(3);
    chk("sf_starts",  32'(start_cnt - s0), 32'd1);
    chk("sf_len",     32'(prog_len),       32'd1);
    chk("sf_mem0",    mem_log[0],          32'hA000_0000);
    chk("sf_mem7",    mem_log[7],          32'hA000_0007);
    chk("sf_busy",    32'(core_ready),     32'd0);
    drive(0, 0, 0, 0, 1);
    idle(2);
    chk("sf_ready",   32'(core_ready),     32'd1);

    // Destination miss.
    w0 = wr_cnt;
    drive(1, 1, 32'h3, 16'h000B, 0);
    idle(2);
    chk("miss_ready",  32'(core_ready),  32'd1);
    chk("miss_writes", 32'(wr_cnt - w0), 32'd0);

    // Bad headers, then a valid one clears the error.
    drive(1, 1, 32'd0, 16'h0004, 0);
    idle(1);
    chk("bad0_err", 32'(load_error), 32'd1);
    drive(1, 1, 32'd33, 16'h0004, 0);
    idle(1);
    chk("bad33_err",    32'(load_error),  32'd1);
    chk("bad_writes",   32'(wr_cnt - w0), 32'd0);
    drive(1, 1, 32'd1, 16'h0004, 0);
    idle(1);
    chk("good_clr_err", 32'(load_error), 32'd0);
    for (int i = 0; i < BPF; i++) drive(1, 0, 32'h1111_0000 + 32'(i), 16'h0004, 0);
    idle(2);
    drive(0, 0, 0, 0, 1);
    idle(2);

    // Header in the middle of a load.
    s0 = start_cnt;
    drive(1, 1, 32'd1, 16'h0004, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 32'hB000_0000 + 32'(i), 16'h0004, 0);
    load_frames(2, 32'hC000_0000);
    idle(3);
    chk("mid_starts", 32'(start_cnt - s0), 32'd1);
    chk("mid_len",    32'(prog_len),       32'd2);
    chk("mid_err",    32'(load_error),     32'd1);
    chk("mid_mem0",   mem_log[0],          32'hC000_0000);
    chk("mid_mem15",  mem_log[15],         32'hC000_000F);

    // Backpressure while running.
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) drive(1, 0, 32'hDEAD_0000, 16'h0004, 0);
    chk("run_bus_ready", 32'(bus_ready),   32'd0);
    idle(1);
    chk("run_writes",    32'(wr_cnt - w0), 32'd0);
    drive(0, 0, 0, 0, 1);
    idle(2);

    // Reset mid-load.
    s0 = start_cnt;
    drive(1, 1, 32'd1, 16'h0004, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 32'hE000_0000 + 32'(i), 16'h0004, 0);
    @(negedge clk); #2; reset = 1'b0; #1;
    chk("arst_core_ready",   32'(core_ready),   32'd1);
    chk("arst_bus_ready",    32'(bus_ready),    32'd1);
    chk("arst_core_reading", 32'(core_reading), 32'd0);
    chk("arst_imem_we",      32'(imem_we),      32'd0);
    chk("arst_imem_addr",    32'(imem_addr),    32'd0);
    chk("arst_prog_len",     32'(prog_len),     32'd0);
    idle(2);
    @(negedge clk); #1; reset = 1'b1;
    idle(12);
    chk("arst_no_start", 32'(start_cnt - s0), 32'd0);

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit v, s, done;
      logic [15:0] dst;
      logic [31:0] d;
      v = ($urandom % 4) != 0;
      s = (m_phase == 1) ? (($urandom % 40) == 0) : (($urandom % 6) == 0);
      dst = 16'($urandom);
      if (($urandom % 4) != 0) dst[2] = 1'b1;
      if (s) begin
        case ($urandom_range(0, 5))
          0:       d = 32'h0;
          1:       d = {16'($urandom), 16'd33};
          2:       d = {16'($urandom), 16'd32};
          default: d = {16'($urandom), 16'($urandom_range(1, 3))};
        endcase
      end else begin
        d = $urandom;
      end
      done = ($urandom % 12) == 0;
      drive(v, s, d, dst, done);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
